mkio_rx_decoder: RTL and testbench

- Parametrised MIL-STD-1553B (MKIO) Manchester-II word receiver for one bus channel.
- Decodes the differential transceiver outputs (di1/di0) into sync type, data field and parity status, and flags Manchester and parity errors.
- Handles back-to-back words with no inter-word gap.
- Sits between the channel transceiver pins and the mkio remote-terminal protocol logic; one instance per channel (A, B).

---
 rtl/mkio_pkg.sv | 38 +++
 rtl/mkio_line_sync.sv | 32 +++
 rtl/mkio_rx_decoder.sv | 229 ++++++++++++++++++++++
 tb/tb_mkio_rx_decoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mkio_pkg.sv
// MIL-STD-1553B (MKIO) shared definitions: line-state and receiver FSM
// encodings, sync pattern constants and counter-width helpers.
package mkio_pkg;

   // Decoded differential line state (di1,di0): 10 = HI, 01 = LO, 00/11 = NUL
   typedef enum logic [1:0] {
      LINE_NUL = 2'b00,
      LINE_LO  = 2'b01,
      LINE_HI  = 2'b10
   } line_t;

   // Word receiver FSM states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SYNC2 = 2'b01,
      ST_BITS  = 2'b10,
      ST_DONE  = 2'b11
   } rx_state_t;

   // Command/status sync starts HI; data sync starts LO. Each sync half is 3 half-bits.
   localparam line_t       SYNC_CMD_FIRST = LINE_HI;
   localparam int unsigned SYNC_HALFBITS  = 3;

   // Map raw synchronized pin pair to a line state
   function automatic line_t line_decode(input logic [1:0] pins);
      case (pins)
         2'b10:   return LINE_HI;
         2'b01:   return LINE_LO;
         default: return LINE_NUL;
      endcase
   endfunction

   // Bits needed to hold values 0..max_val
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/mkio_line_sync.sv
// Two-flop synchronizer for the asynchronous transceiver lines followed by
// line-state decode. Shared by the MKIO receiver and encoder.
//   clk, reset   : clock, asynchronous active-high reset
//   i_di1, i_di0 : raw transceiver outputs (asynchronous)
//   o_line_c     : decoded line state of the synchronized pins (combinational)
module mkio_line_sync
   import mkio_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  i_di1,
   input  logic  i_di0,
   output line_t o_line_c
);

   logic [1:0] r_meta;
   logic [1:0] r_sync;

   // Metastability filter
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= 2'b00;
         r_sync <= 2'b00;
      end else begin
         r_meta <= {i_di1, i_di0};
         r_sync <= r_meta;
      end
   end

   assign o_line_c = line_decode(r_sync);

endmodule

// File: rtl/mkio_rx_decoder.sv
// MIL-STD-1553B Manchester-II word receiver for one bus channel. Qualifies the
// sync mid-edge from the run length, samples every bit at its half-bit centres,
// and reports sync type, data field, parity and Manchester errors.
// Optional build macro MKIO_RX_RESYNC_EN: valid mid-bit transitions re-align
// the sample phase; undefined, samples are free-running from the sync mid-edge.
//   clk, reset      : clock, asynchronous active-high reset
//   rx_en           : receiver enable, low aborts a word and forces IDLE
//   di1, di0        : transceiver lines (asynchronous)
//   rx_strob        : registered rx_en
//   rx_busy         : word in progress
//   rx_valid        : one-cycle pulse, word done or Manchester error
//   rx_cmd          : 1 = command/status sync, 0 = data sync
//   rx_data         : decoded field, MSB first on the line
//   rx_par_err      : odd-parity failure
//   rx_manch_err    : Manchester violation
module mkio_rx_decoder
   import mkio_pkg::*;
#(
   parameter int unsigned CLK_PER_HALFBIT = 16,
   parameter int unsigned DATA_W          = 16,
   parameter int unsigned SYNC_TOL        = 3
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_en,
   input  logic              di1,
   input  logic              di0,
   output logic              rx_strob,
   output logic              rx_busy,
   output logic              rx_valid,
   output logic              rx_cmd,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_par_err,
   output logic              rx_manch_err
);

   localparam int unsigned H       = CLK_PER_HALFBIT;
   localparam int unsigned RUN_MAX = 8 * H;
   localparam int unsigned RUN_W   = cnt_w(RUN_MAX);
   localparam int unsigned T_W     = cnt_w(SYNC_HALFBITS * H);
   localparam int unsigned PH_W    = cnt_w(2 * H - 1);
   localparam int unsigned BIT_W   = cnt_w(DATA_W);
   localparam int unsigned RUN_LO  = SYNC_HALFBITS * H - SYNC_TOL;
   // Upper bound allows the sync first half to merge with the previous parity half
   localparam int unsigned RUN_HI  = (SYNC_HALFBITS + 1) * H + SYNC_TOL;

   line_t             w_line;
   logic              w_change;
   logic              w_hilo_edge;
   logic              w_sample_bit;
   logic              w_manch_bad;

   line_t             r_prev;
   logic [RUN_W-1:0]  r_run;

   rx_state_t         r_state,    w_state_n;
   logic [T_W-1:0]    r_t,        w_t_n;
   logic [PH_W-1:0]   r_ph,       w_ph_n;
   logic [BIT_W-1:0]  r_bit,      w_bit_n;
   logic [DATA_W-1:0] r_shift,    w_shift_n;
   line_t             r_first,    w_first_n;
   logic              r_cmd_word, w_cmd_word_n;

   logic              r_strob;
   logic              r_busy,     w_busy_n;
   logic              r_valid,    w_valid_n;
   logic              r_cmd,      w_cmd_n;
   logic [DATA_W-1:0] r_data,     w_data_n;
   logic              r_par_err,  w_par_err_n;
   logic              r_manch,    w_manch_n;

   mkio_line_sync u_line_sync (
      .clk      (clk),
      .reset    (reset),
      .i_di1    (di1),
      .i_di0    (di0),
      .o_line_c (w_line)
   );

   assign w_change    = (w_line != r_prev);
   assign w_hilo_edge = w_change && (w_line != LINE_NUL) && (r_prev != LINE_NUL);

   // Run counter: clocks the previous line state has been held, saturating.
   // Free-running so a back-to-back sync merged with the parity half still qualifies.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_prev <= LINE_NUL;
         r_run  <= '0;
      end else begin
         r_prev <= w_line;
         if (w_change)
            r_run <= RUN_W'(1);
         else if (r_run != RUN_W'(RUN_MAX))
            r_run <= r_run + RUN_W'(1);
      end
   end

   // State and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_t        <= '0;
         r_ph       <= '0;
         r_bit      <= '0;
         r_shift    <= '0;
         r_first    <= LINE_NUL;
         r_cmd_word <= 1'b0;
         r_strob    <= 1'b0;
         r_busy     <= 1'b0;
         r_valid    <= 1'b0;
         r_cmd      <= 1'b0;
         r_data     <= '0;
         r_par_err  <= 1'b0;
         r_manch    <= 1'b0;
      end else begin
         r_state    <= w_state_n;
         r_t        <= w_t_n;
         r_ph       <= w_ph_n;
         r_bit      <= w_bit_n;
         r_shift    <= w_shift_n;
         r_first    <= w_first_n;
         r_cmd_word <= w_cmd_word_n;
         r_strob    <= rx_en;
         r_busy     <= w_busy_n;
         r_valid    <= w_valid_n;
         r_cmd      <= w_cmd_n;
         r_data     <= w_data_n;
         r_par_err  <= w_par_err_n;
         r_manch    <= w_manch_n;
      end
   end

   // Next-state and output logic
   always_comb begin
      w_state_n    = r_state;
      w_t_n        = r_t;
      w_ph_n       = r_ph;
      w_bit_n      = r_bit;
      w_shift_n    = r_shift;
      w_first_n    = r_first;
      w_cmd_word_n = r_cmd_word;
      w_valid_n    = 1'b0;
      w_cmd_n      = r_cmd;
      w_data_n     = r_data;
      w_par_err_n  = r_par_err;
      w_manch_n    = r_manch;
      w_sample_bit = (r_first == LINE_HI);
      w_manch_bad  = (r_first == LINE_NUL) || (w_line == LINE_NUL) || (w_line == r_first);

      if (!rx_en) begin
         w_state_n = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // Sync mid-edge: HI<->LO after a run of roughly three half-bits
               if (w_hilo_edge && (r_run >= RUN_W'(RUN_LO)) && (r_run <= RUN_W'(RUN_HI))) begin
                  w_state_n    = ST_SYNC2;
                  w_t_n        = T_W'(1);
                  w_cmd_word_n = (r_prev == SYNC_CMD_FIRST);
               end
            end

            ST_SYNC2: begin
               w_t_n = r_t + T_W'(1);
               if (w_change && (r_t < T_W'(RUN_LO))) begin
                  w_state_n = ST_IDLE;
               end else if (r_t == T_W'(SYNC_HALFBITS * H - 1)) begin
                  // Next cycle is the start of bit 0
                  w_state_n = ST_BITS;
                  w_ph_n    = '0;
                  w_bit_n   = '0;
               end
            end

            ST_BITS: begin
               w_ph_n = (r_ph == PH_W'(2 * H - 1)) ? '0 : r_ph + PH_W'(1);
`ifdef MKIO_RX_RESYNC_EN
               // Mid-bit transition marks phase H; realign so later samples track it
               if (w_hilo_edge && (r_ph > PH_W'(H / 2)) && (r_ph < PH_W'(3 * H / 2)))
                  w_ph_n = PH_W'(H + 1);
`endif
               if (r_ph == PH_W'(H / 2))
                  w_first_n = w_line;

               if (r_ph == PH_W'(3 * H / 2)) begin
                  if (w_manch_bad) begin
                     w_state_n   = ST_IDLE;
                     w_valid_n   = 1'b1;
                     w_manch_n   = 1'b1;
                     w_par_err_n = 1'b0;
                     w_data_n    = '0;
                     w_cmd_n     = r_cmd_word;
                  end else if (r_bit == BIT_W'(DATA_W)) begin
                     // Parity bit: total ones over data plus parity must be odd
                     w_state_n   = ST_DONE;
                     w_valid_n   = 1'b1;
                     w_manch_n   = 1'b0;
                     w_par_err_n = ~((^r_shift) ^ w_sample_bit);
                     w_data_n    = r_shift;
                     w_cmd_n     = r_cmd_word;
                  end else begin
                     w_shift_n = {r_shift[DATA_W-2:0], w_sample_bit};
                     w_bit_n   = r_bit + BIT_W'(1);
                  end
               end
            end

            ST_DONE: begin
               w_state_n = ST_IDLE;
            end

            default: begin
               w_state_n = ST_IDLE;
            end
         endcase
      end

      w_busy_n = (w_state_n == ST_SYNC2) || (w_state_n == ST_BITS);
   end

   assign rx_strob     = r_strob;
   assign rx_busy      = r_busy;
   assign rx_valid     = r_valid;
   assign rx_cmd       = r_cmd;
   assign rx_data      = r_data;
   assign rx_par_err   = r_par_err;
   assign rx_manch_err = r_manch;

endmodule

// File: tb/tb_mkio_rx_decoder.sv
// Self-checking bench for mkio_rx_decoder: line-level word generator, expected
// word list derived from the 1553 word rules, and a monitor collecting every
// rx_valid pulse for comparison.
`timescale 1ns/1ps
module tb_mkio_rx_decoder;

   localparam int unsigned H  = 16;
   localparam int unsigned DW = 16;
   localparam logic [1:0] L_NUL = 2'b00;
   localparam logic [1:0] L_LO  = 2'b01;
   localparam logic [1:0] L_HI  = 2'b10;

   typedef struct packed {
      logic          cmd;
      logic          par_err;
      logic          manch;
      logic [DW-1:0] data;
   } rec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          rx_en;
   logic          di1;
   logic          di0;
   logic          rx_strob;
   logic          rx_busy;
   logic          rx_valid;
   logic          rx_cmd;
   logic [DW-1:0] rx_data;
   logic          rx_par_err;
   logic          rx_manch_err;

   int   n_checks = 0;
   int   n_errors = 0;
   int   busy_cycles = 0;
   int   rd_idx = 0;
   rec_t obs_q[$];
   rec_t exp_q[$];

   always #5 clk = ~clk;

   mkio_rx_decoder #(
      .CLK_PER_HALFBIT (H),
      .DATA_W          (DW),
      .SYNC_TOL        (3)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_en        (rx_en),
      .di1          (di1),
      .di0          (di0),
      .rx_strob     (rx_strob),
      .rx_busy      (rx_busy),
      .rx_valid     (rx_valid),
      .rx_cmd       (rx_cmd),
      .rx_data      (rx_data),
      .rx_par_err   (rx_par_err),
      .rx_manch_err (rx_manch_err)
   );

   // Collect every reported word
   always @(negedge clk) begin
      if (rx_valid)
         obs_q.push_back(rec_t'{cmd: rx_cmd, par_err: rx_par_err, manch: rx_manch_err, data: rx_data});
      if (rx_busy)
         busy_cycles++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Hold a line level for n clocks (called and returning at a negedge)
   task automatic drive(input logic [1:0] lvl, input int unsigned n);
      {di1, di0} = lvl;
      repeat (n) @(negedge clk);
   endtask

   // One word on the line; bad_bit >= 0 drives that bit HI/HI and stops there
   task automatic send_word(input bit cmd, input logic [DW-1:0] data, input bit par,
                            input int bad_bit, input int unsigned first_len);
      logic [DW:0] bits;
      bits = {data, par};
      drive(cmd ? L_HI : L_LO, first_len);
      drive(cmd ? L_LO : L_HI, 3 * H);
      for (int i = 0; i <= DW; i++) begin
         if (i == bad_bit) begin
            drive(L_HI, 2 * H);
            return;
         end
         if (bits[DW - i]) begin
            drive(L_HI, H);
            drive(L_LO, H);
         end else begin
            drive(L_LO, H);
            drive(L_HI, H);
         end
      end
   endtask

   // Reference: what the receiver must report for a word
   task automatic expect_word(input bit cmd, input logic [DW-1:0] data, input bit par, input int bad_bit);
      rec_t r;
      if (bad_bit >= 0) begin
         r = rec_t'{cmd: cmd, par_err: 1'b0, manch: 1'b1, data: '0};
      end else begin
         r = rec_t'{cmd: cmd, par_err: ($countones({data, par}) % 2 == 0), manch: 1'b0, data: data};
      end
      exp_q.push_back(r);
   endtask

   task automatic send_and_expect(input bit cmd, input logic [DW-1:0] data, input bit par, input int bad_bit);
      expect_word(cmd, data, par, bad_bit);
      send_word(cmd, data, par, bad_bit, 3 * H);
   endtask

   // Compare reported words since the last call against the expected list
   task automatic check_words(input string tag);
      int n_obs;
      rec_t o;
      rec_t e;
      n_obs = obs_q.size() - rd_idx;
      check_eq({tag, "_count"}, 32'(n_obs), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < n_obs) begin
            o = obs_q[rd_idx + i];
            e = exp_q[i];
            check_eq({tag, "_manch"}, 32'(o.manch), 32'(e.manch));
            check_eq({tag, "_data"}, 32'(o.data), 32'(e.data));
            if (!e.manch) begin
               check_eq({tag, "_cmd"}, 32'(o.cmd), 32'(e.cmd));
               check_eq({tag, "_par"}, 32'(o.par_err), 32'(e.par_err));
            end
         end
      end
      rd_idx = obs_q.size();
      exp_q.delete();
   endtask

   function automatic bit odd_par(input logic [DW-1:0] d);
      return ~(^d);
   endfunction

   initial begin
      int   busy0;
      bit   prev_bad;
      int   kind;
      int   bad;
      bit   cmd;
      logic [DW-1:0] data;
      bit   par;

      reset = 1'b1;
      rx_en = 1'b1;
      {di1, di0} = L_NUL;
      repeat (3) @(negedge clk);
      check_eq("rst_valid", 32'(rx_valid), 0);
      check_eq("rst_busy", 32'(rx_busy), 0);
      check_eq("rst_strob", 32'(rx_strob), 0);
      check_eq("rst_data", 32'(rx_data), 0);
      check_eq("rst_flags", 32'({rx_cmd, rx_par_err, rx_manch_err}), 0);
      reset = 1'b0;
      @(negedge clk);
      check_eq("strob_en", 32'(rx_strob), 1);
      drive(L_NUL, 2 * H);

      // Command word 0x0867 with correct parity
      send_and_expect(1'b1, 16'h0867, 1'b1, -1);
      drive(L_NUL, 4 * H);
      check_words("cmd0867");

      // Command then seven contiguous data words FFFF/0000
      send_and_expect(1'b1, 16'h0867, 1'b1, -1);
      for (int i = 0; i < 7; i++) begin
         data = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
         send_and_expect(1'b0, data, odd_par(data), -1);
      end
      drive(L_NUL, 4 * H);
      check_words("contig");

      // Parity bit inverted
      send_and_expect(1'b0, 16'h1234, ~odd_par(16'h1234), -1);
      drive(L_NUL, 4 * H);
      check_words("parerr");

      // Bit 5 driven HI for both halves
      send_and_expect(1'b0, 16'hA5C3, odd_par(16'hA5C3), 5);
      drive(L_NUL, 4 * H);
      check_words("manch5");

      // Sync first half only 2H: must not start a word
      busy0 = busy_cycles;
      drive(L_HI, 2 * H);
      drive(L_LO, 2 * H);
      drive(L_NUL, 4 * H);
      check_eq("short_busy_cnt", 32'(busy_cycles - busy0), 0);
      // Good first half but the second half cut short: silent abort
      busy0 = busy_cycles;
      drive(L_HI, 3 * H);
      drive(L_LO, 2 * H);
      drive(L_NUL, 4 * H);
      check_eq("abort_busy_seen", 32'(busy_cycles - busy0 > 0), 1);
      check_eq("abort_busy_end", 32'(rx_busy), 0);
      check_words("sync_abort");
      send_and_expect(1'b0, 16'h5A0F, odd_par(16'h5A0F), -1);
      drive(L_NUL, 4 * H);
      check_words("after_abort");

      // rx_en dropped during bit 10
      fork
         begin
            send_word(1'b0, 16'hBEEF, odd_par(16'hBEEF), -1, 3 * H);
            drive(L_NUL, 4 * H);
         end
         begin
            repeat (6 * H + 20 * H + H / 2) @(negedge clk);
            check_eq("en_busy_before", 32'(rx_busy), 1);
            rx_en = 1'b0;
            @(negedge clk);
            check_eq("en_busy_after", 32'(rx_busy), 0);
            check_eq("en_strob_low", 32'(rx_strob), 0);
         end
      join
      check_words("en_drop");
      rx_en = 1'b1;
      @(negedge clk);
      check_eq("en_strob_high", 32'(rx_strob), 1);

      // Asynchronous reset mid-word after a good word
      send_and_expect(1'b1, 16'h0867, 1'b1, -1);
      drive(L_NUL, 4 * H);
      check_words("pre_reset");
      fork
         begin
            send_word(1'b1, 16'h7E81, odd_par(16'h7E81), -1, 3 * H);
            drive(L_NUL, 4 * H);
         end
         begin
            repeat (6 * H + 16 * H) @(negedge clk);
            check_eq("mid_busy", 32'(rx_busy), 1);
            reset = 1'b1;
            #1;
            check_eq("arst_busy", 32'(rx_busy), 0);
            check_eq("arst_data", 32'(rx_data), 0);
            check_eq("arst_flags", 32'({rx_valid, rx_cmd, rx_par_err, rx_manch_err, rx_strob}), 0);
            @(negedge clk);
            reset = 1'b0;
         end
      join
      check_words("arst_word");

      // Randomized word stream, back-to-back or with gaps
      prev_bad = 1'b1;
      for (int w = 0; w < 28; w++) begin
         kind = $urandom_range(0, 9);
         cmd  = 1'($urandom_range(0, 1));
         data = 16'($urandom);
         par  = odd_par(data);
         bad  = -1;
         if (kind == 7) par = ~par;
         if (kind >= 8) bad = $urandom_range(0, DW);
         if (prev_bad || ($urandom_range(0, 1) == 1))
            drive(L_NUL, $urandom_range(2, 30));
         send_and_expect(cmd, data, par, bad);
         prev_bad = (bad >= 0);
      end
      drive(L_NUL, 4 * H);
      check_words("random");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
